servo_pwm_array: RTL

Multi-channel hobby-servo PWM generator producing `NUM_CH` independent pulse outputs sharing one frame timebase. A host-side register interface (typically the SPI slave command decoder) writes per-channel pulse widths in microseconds. Values are clamped to a safe servo range and double-buffered so updates take effect only at frame boundaries. Optional per-frame slew limiting is available. Sits between the SPI command decoder and the servo output pins.

---
 rtl/servo_pwm_array.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/servo_pwm_array.sv
// servo_pwm_array: NUM_CH servo pulse outputs on one shared frame timebase, with clamped,
// frame-synchronous double-buffered widths. Define SERVO_RAMP_EN for per-frame slew limiting.
module servo_pwm_array #(
  parameter int NUM_CH       = 8,
  parameter int CH_SEL_W     = 3,
  parameter int DATA_W       = 16,
  parameter int TICKS_PER_US = 100,
  parameter int PERIOD_US    = 20000,
  parameter int MIN_US       = 500,
  parameter int MAX_US       = 2500,
  parameter int RAMP_STEP_US = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CH_SEL_W-1:0] ch_sel,
  input  logic [DATA_W-1:0]   data,
  output logic [NUM_CH-1:0]   signal,
  output logic                frame_start,
  output logic [NUM_CH-1:0]   pending
);

  localparam int TICK_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int US_W   = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int CMP_W  = (DATA_W > 32) ? DATA_W : 32;
  localparam int STEP   = (RAMP_STEP_US >= PERIOD_US) ? (PERIOD_US - 1) : RAMP_STEP_US;

  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_US - 1);
  localparam logic [US_W-1:0]   US_ZERO   = {US_W{1'b0}};
  localparam logic [US_W-1:0]   US_ONE    = US_W'(1);
  localparam logic [US_W-1:0]   US_LAST   = US_W'(PERIOD_US - 1);
  localparam logic [US_W-1:0]   MIN_W     = US_W'(MIN_US);
  localparam logic [US_W-1:0]   MAX_W     = US_W'(MAX_US);
  localparam logic [US_W-1:0]   STEP_W    = US_W'(STEP);

  // Clamp is evaluated on the full write value so large requests cannot wrap into range.
  function automatic logic [US_W-1:0] clamp_width(input logic [DATA_W-1:0] d);
    logic [CMP_W-1:0] v;
    logic [US_W-1:0]  w;
    v = CMP_W'(d);
    if (v == {CMP_W{1'b0}}) begin
      w = US_ZERO;
    end else if (v < CMP_W'(MIN_US)) begin
      w = MIN_W;
    end else if (v > CMP_W'(MAX_US)) begin
      w = MAX_W;
    end else begin
      w = US_W'(d);
    end
    return w;
  endfunction

  // One slew step toward the target; enabling or disabling a channel jumps directly.
  function automatic logic [US_W-1:0] ramp_toward(input logic [US_W-1:0] cur,
                                                  input logic [US_W-1:0] tgt);
    logic [US_W-1:0] nxt;
    if ((cur == US_ZERO) || (tgt == US_ZERO)) begin
      nxt = tgt;
    end else if (tgt > cur) begin
      nxt = ((tgt - cur) > STEP_W) ? (cur + STEP_W) : tgt;
    end else begin
      nxt = ((cur - tgt) > STEP_W) ? (cur - STEP_W) : tgt;
    end
    return nxt;
  endfunction

  logic                running;
  logic [TICK_W-1:0]   tick_cnt;
  logic [US_W-1:0]     us_cnt;
  logic [US_W-1:0]     shadow [NUM_CH];
  logic [US_W-1:0]     active [NUM_CH];

  logic [TICK_W-1:0]   tick_n;
  logic [US_W-1:0]     us_n;
  logic                boundary_n;
  logic [US_W-1:0]     shadow_n [NUM_CH];
  logic [US_W-1:0]     active_n [NUM_CH];
  logic [NUM_CH-1:0]   signal_n;
  logic [NUM_CH-1:0]   pending_n;

  // Next-state: outputs are registered from the state the next cycle will hold,
  // so signal/pending/frame_start line up with the counter position they describe.
  always_comb begin
    tick_n     = tick_cnt;
    us_n       = us_cnt;
    boundary_n = 1'b0;
    signal_n   = {NUM_CH{1'b0}};
    pending_n  = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_n[c] = shadow[c];
      active_n[c] = active[c];
    end

    // The first cycle after reset is itself a frame boundary, so hold position once.
    if (!running) begin
      tick_n = TICK_ZERO;
      us_n   = US_ZERO;
    end else if (tick_cnt == TICK_LAST) begin
      tick_n = TICK_ZERO;
      if (us_cnt == US_LAST) begin
        us_n = US_ZERO;
      end else begin
        us_n = us_cnt + US_ONE;
      end
    end else begin
      tick_n = tick_cnt + TICK_ONE;
    end
    boundary_n = (tick_n == TICK_ZERO) && (us_n == US_ZERO);

    for (int c = 0; c < NUM_CH; c++) begin
      if (load && (ch_sel == CH_SEL_W'(c))) begin
        shadow_n[c] = clamp_width(data);
      end else begin
        shadow_n[c] = shadow[c];
      end

      if (boundary_n) begin
`ifdef SERVO_RAMP_EN
        active_n[c] = ramp_toward(active[c], shadow_n[c]);
`else
        active_n[c] = shadow_n[c];
`endif
      end else begin
        active_n[c] = active[c];
      end

      signal_n[c]  = (us_n < active_n[c]);
      pending_n[c] = (shadow_n[c] != active_n[c]);
    end
  end

  // State and registered outputs; reset overrides any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      running     <= 1'b0;
      tick_cnt    <= TICK_ZERO;
      us_cnt      <= US_ZERO;
      signal      <= {NUM_CH{1'b0}};
      pending     <= {NUM_CH{1'b0}};
      frame_start <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= US_ZERO;
        active[c] <= US_ZERO;
      end
    end else begin
      running     <= 1'b1;
      tick_cnt    <= tick_n;
      us_cnt      <= us_n;
      signal      <= signal_n;
      pending     <= pending_n;
      frame_start <= boundary_n;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= shadow_n[c];
        active[c] <= active_n[c];
      end
    end
  end

endmodule
